// File: rtl/reflet_mem_unit_pkg.sv
// Shared Reflet constants: opcodes, register ids, access sizes, FSM states.
// Imported by the memory unit and its lane helper.
package reflet_mem_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_ACCESS,
        ST_COMPLETE
    } state_t;

    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_POP,
        MOP_PUSH,
        MOP_CALL,
        MOP_RET,
        MOP_LOAD,
        MOP_STR
    } mop_t;

    localparam logic [7:0] INST_POP  = 8'h09;
    localparam logic [7:0] INST_PUSH = 8'h0A;
    localparam logic [7:0] INST_CALL = 8'h0B;
    localparam logic [7:0] INST_RET  = 8'h0C;

    localparam logic [3:0] OPP_STR  = 4'hE;
    localparam logic [3:0] OPP_LOAD = 4'hF;
    localparam logic [3:0] PC_ID    = 4'h2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_8    = 2'b01;
    localparam logic [1:0] SZ_16   = 2'b10;
    localparam logic [1:0] SZ_32   = 2'b11;

    function automatic mop_t decode_mop(input logic [7:0] inst);
        mop_t m;
        m = MOP_NONE;
        unique case (1'b1)
            (inst == INST_POP):       m = MOP_POP;
            (inst == INST_PUSH):      m = MOP_PUSH;
            (inst == INST_CALL):      m = MOP_CALL;
            (inst == INST_RET):       m = MOP_RET;
            (inst[7:4] == OPP_LOAD):  m = MOP_LOAD;
            (inst[7:4] == OPP_STR):   m = MOP_STR;
            default:                  m = MOP_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/reflet_mem_unit_if.sv
// Variable-latency req/ack memory port of the Reflet core.
// master = memory unit, slave = memory / bus fabric.
interface reflet_mem_unit_if #(
    parameter int WORDSIZE = 16
) ();
    localparam int LANES = WORDSIZE / 8;

    logic [WORDSIZE-1:0] mem_addr;
    logic [WORDSIZE-1:0] mem_wdata;
    logic [LANES-1:0]    mem_be;
    logic                mem_we;
    logic                mem_req;
    logic                mem_ack;
    logic [WORDSIZE-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_be, mem_we, mem_req,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_be, mem_we, mem_req,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/reflet_mem_lane.sv
// Byte-lane steering: enables, write replication, read extraction and
// alignment check for one access of nbytes_i bytes (power of two).
module reflet_mem_lane #(
    parameter int WORDSIZE = 16
) (
    input  logic [2:0]            addr_lo_i,
    input  logic [3:0]            nbytes_i,
    input  logic [WORDSIZE-1:0]   wdata_i,
    input  logic [WORDSIZE-1:0]   rdata_i,
    output logic [WORDSIZE/8-1:0] be_o,
    output logic [WORDSIZE-1:0]   wdata_o,
    output logic [WORDSIZE-1:0]   rdata_o,
    output logic                  misaligned_o
);
    localparam int LANES = WORDSIZE / 8;
    localparam logic [2:0] OFF_MASK = 3'(LANES - 1);

    logic [2:0]          off;
    int                  offs;
    int                  nb;
    logic [WORDSIZE-1:0] mask;
    logic [WORDSIZE-1:0] shifted;

    assign off = addr_lo_i & OFF_MASK;
    assign misaligned_o = (addr_lo_i & 3'(nbytes_i - 4'd1)) != 3'd0;

    always_comb begin
        offs    = int'(off);
        nb      = int'(nbytes_i);
        mask    = '0;
        be_o    = '0;
        wdata_o = '0;
        shifted = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < nb) mask[8*i +: 8] = 8'hFF;
            if (i >= offs && i < offs + nb) be_o[i] = 1'b1;
            // lane i carries byte (i mod nb) of the source
            shifted = wdata_i >> (8 * (i & (nb - 1)));
            wdata_o[8*i +: 8] = shifted[7:0];
        end
        rdata_o = (rdata_i >> (8 * offs)) & mask;
    end

endmodule

// File: rtl/reflet_mem_unit.sv
// Reflet fetch/load/store/stack sequencer over a req/ack memory port.
// FETCH -> DECODE -> [ACCESS] -> COMPLETE, with alignment and wait timeout.
module reflet_mem_unit
    import reflet_mem_unit_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORDSIZE-1:0] working_register,
    input  logic [WORDSIZE-1:0] program_counter,
    input  logic [WORDSIZE-1:0] stack_pointer,
    input  logic [WORDSIZE-1:0] other_register,
    input  logic [1:0]          access_size,
    output logic [7:0]          instruction,
    output logic                cpu_stall,
    output logic [WORDSIZE-1:0] result,
    output logic [3:0]          result_reg,
    output logic                result_valid,
    output logic                bus_error,
    reflet_mem_unit_if.master   bus
);
    localparam int LANES = WORDSIZE / 8;
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [3:0] LANES_B = 4'(LANES);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
    localparam bit TMO_EN = (MAX_WAIT != 0);

    state_t              state_q, state_d;
    logic [7:0]          instr_q, instr_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                berr_q, berr_d;

    mop_t                mop;
    logic [3:0]          nbytes;
    logic [WORDSIZE-1:0] op_addr;
    logic [WORDSIZE-1:0] lane_addr;
    logic [3:0]          lane_nb;
    logic [WORDSIZE-1:0] lane_wsrc;
    logic [WORDSIZE-1:0] lane_wdata;
    logic [WORDSIZE-1:0] lane_rdata;
    logic [LANES-1:0]    lane_be;
    logic                misaligned;
    logic                timeout;
    logic                req;
    logic                is_write;

    assign mop = decode_mop(instr_q);

    always_comb begin
        nbytes = LANES_B;
        unique case (access_size)
            SZ_WORD: nbytes = LANES_B;
            SZ_8:    nbytes = 4'd1;
            SZ_16:   nbytes = 4'd2;
            SZ_32:   nbytes = 4'd4;
        endcase
        if (nbytes > LANES_B) nbytes = LANES_B;
    end

    always_comb begin
        op_addr = other_register;
        unique case (mop)
            MOP_PUSH, MOP_CALL: op_addr = stack_pointer;
            MOP_POP, MOP_RET:   op_addr = stack_pointer - WORDSIZE'(nbytes);
            default:            op_addr = other_register;
        endcase
    end

    assign lane_addr = (state_q == ST_FETCH) ? program_counter : op_addr;
    assign lane_nb   = (state_q == ST_FETCH) ? 4'd1 : nbytes;
    assign lane_wsrc = (mop == MOP_CALL) ? program_counter : working_register;

    reflet_mem_lane #(
        .WORDSIZE(WORDSIZE)
    ) u_lane (
        .addr_lo_i   (lane_addr[2:0]),
        .nbytes_i    (lane_nb),
        .wdata_i     (lane_wsrc),
        .rdata_i     (bus.mem_rdata),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata),
        .misaligned_o(misaligned)
    );

    assign timeout = TMO_EN && (wait_q == WAIT_LIM);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        berr_d  = 1'b0;
        req     = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (timeout) begin
                    berr_d = 1'b1;
                    wait_d = '0;
                end else begin
                    req = 1'b1;
                    if (bus.mem_ack) begin
                        instr_d = lane_rdata[7:0];
                        state_d = ST_DECODE;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
            end
            ST_DECODE: begin
                wait_d = '0;
                if (mop == MOP_NONE) begin
                    state_d = ST_COMPLETE;
                end else if (misaligned) begin
                    berr_d  = 1'b1;
                    state_d = ST_COMPLETE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (timeout) begin
                    berr_d  = 1'b1;
                    state_d = ST_COMPLETE;
                end else begin
                    req = 1'b1;
                    if (bus.mem_ack) begin
                        rdata_d = lane_rdata;
                        state_d = ST_COMPLETE;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
            end
            ST_COMPLETE: begin
                wait_d  = '0;
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            instr_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        result     = '0;
        result_reg = '0;
        unique case (mop)
            MOP_POP, MOP_LOAD: result = rdata_q;
            MOP_RET: begin
                result     = rdata_q + WORDSIZE'(1);
                result_reg = PC_ID;
            end
            MOP_CALL: begin
                result     = working_register;
                result_reg = PC_ID;
            end
            MOP_PUSH, MOP_STR: result = working_register;
            default: result = '0;
        endcase
    end

    assign is_write = (mop == MOP_PUSH) || (mop == MOP_CALL) || (mop == MOP_STR);

    // reset gates the port so a held reset kills an open request at once
    assign bus.mem_req   = reset & req;
    assign bus.mem_we    = reset & req & (state_q == ST_ACCESS) & is_write;
    assign bus.mem_be    = (reset & req) ? lane_be : '0;
    assign bus.mem_addr  = lane_addr;
    assign bus.mem_wdata = lane_wdata;

    assign instruction  = instr_q;
    assign cpu_stall    = ~reset | (state_q != ST_COMPLETE);
    assign result_valid = reset & (state_q == ST_COMPLETE)
                        & (mop != MOP_NONE) & ~berr_q;
    assign bus_error    = reset & berr_q;

endmodule

// File: tb/tb_reflet_mem_unit.sv
// Directed bench: a 16-bit unit (MAX_WAIT=4) and a 32-bit unit (MAX_WAIT=255)
// driven through fetch, stack, load/store, alignment, timeout and reset steps.
module tb_reflet_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr, pc, sp, orr;
    logic [1:0]  size;

    logic [7:0]  ins16, ins32;
    logic        st16, st32, rv16, rv32, be16, be32;
    logic [15:0] res16;
    logic [31:0] res32;
    logic [3:0]  rr16, rr32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reflet_mem_unit_if #(.WORDSIZE(16)) if16 ();
    reflet_mem_unit_if #(.WORDSIZE(32)) if32 ();

    reflet_mem_unit #(
        .WORDSIZE(16),
        .MAX_WAIT(4)
    ) u16 (
        .clk             (clk),
        .reset           (rst_n),
        .working_register(wr[15:0]),
        .program_counter (pc[15:0]),
        .stack_pointer   (sp[15:0]),
        .other_register  (orr[15:0]),
        .access_size     (size),
        .instruction     (ins16),
        .cpu_stall       (st16),
        .result          (res16),
        .result_reg      (rr16),
        .result_valid    (rv16),
        .bus_error       (be16),
        .bus             (if16)
    );

    reflet_mem_unit #(
        .WORDSIZE(32),
        .MAX_WAIT(255)
    ) u32 (
        .clk             (clk),
        .reset           (rst_n),
        .working_register(wr),
        .program_counter (pc),
        .stack_pointer   (sp),
        .other_register  (orr),
        .access_size     (size),
        .instruction     (ins32),
        .cpu_stall       (st32),
        .result          (res32),
        .result_reg      (rr32),
        .result_valid    (rv32),
        .bus_error       (be32),
        .bus             (if32)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic ack16_cycle();
        if16.mem_ack = 1'b1;
        tick();
        if16.mem_ack = 1'b0;
        #1;
    endtask

    task automatic ack32_cycle();
        if32.mem_ack = 1'b1;
        tick();
        if32.mem_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr = '0; pc = '0; sp = '0; orr = '0; size = 2'b00;
        if16.mem_ack = 1'b0; if16.mem_rdata = '0;
        if32.mem_ack = 1'b0; if32.mem_rdata = '0;
        tick();
        tick();

        chk("rst_req", if32.mem_req, 1'b0);
        chk("rst_we", if32.mem_we, 1'b0);
        chk("rst_be", if32.mem_be, 4'b0000);
        chk("rst_stall", st32, 1'b1);
        chk("rst_instr", ins32, 8'h00);
        chk("rst_rvalid", rv32, 1'b0);
        chk("rst_berr", be32, 1'b0);

        // non-memory instruction, zero-wait, 16-bit
        pc = 32'h0010;
        if16.mem_rdata = 16'h9942;
        rst_n = 1'b1;
        #1;
        chk("t1_req", if16.mem_req, 1'b1);
        chk("t1_addr", if16.mem_addr, 16'h0010);
        chk("t1_be_even", if16.mem_be, 2'b01);
        chk("t1_we", if16.mem_we, 1'b0);
        chk("t1_stall_f", st16, 1'b1);
        ack16_cycle();
        chk("t1_instr", ins16, 8'h42);
        chk("t1_req_dec", if16.mem_req, 1'b0);
        chk("t1_stall_d", st16, 1'b1);
        tick();
        chk("t1_stall_c", st16, 1'b0);
        chk("t1_rvalid", rv16, 1'b0);
        pc = 32'h0011;
        if16.mem_rdata = 16'h7342;
        tick();
        chk("t1_stall_f2", st16, 1'b1);
        chk("t1_be_odd", if16.mem_be, 2'b10);
        ack16_cycle();
        chk("t1_instr_odd", ins16, 8'h73);

        // call then ret, 16-bit full word
        pc = 32'h0040; wr = 32'h0200; sp = 32'h0080; size = 2'b00;
        if16.mem_rdata = 16'h000B;
        do_reset();
        ack16_cycle();
        chk("t3_instr_call", ins16, 8'h0B);
        tick();
        chk("t3_req", if16.mem_req, 1'b1);
        chk("t3_we", if16.mem_we, 1'b1);
        chk("t3_addr", if16.mem_addr, 16'h0080);
        chk("t3_wdata", if16.mem_wdata, 16'h0040);
        chk("t3_be", if16.mem_be, 2'b11);
        ack16_cycle();
        chk("t3_stall_c", st16, 1'b0);
        chk("t3_result", res16, 16'h0200);
        chk("t3_reg", rr16, 4'h2);
        chk("t3_rvalid", rv16, 1'b1);
        chk("t3_berr", be16, 1'b0);
        pc = 32'h0042; sp = 32'h0082;
        if16.mem_rdata = 16'h000C;
        tick();
        ack16_cycle();
        chk("t3_instr_ret", ins16, 8'h0C);
        tick();
        chk("t3_ret_addr", if16.mem_addr, 16'h0080);
        chk("t3_ret_we", if16.mem_we, 1'b0);
        chk("t3_ret_be", if16.mem_be, 2'b11);
        if16.mem_rdata = 16'h0040;
        ack16_cycle();
        chk("t3_ret_result", res16, 16'h0041);
        chk("t3_ret_reg", rr16, 4'h2);
        chk("t3_ret_rvalid", rv16, 1'b1);

        // misaligned 16-bit load at odd address
        pc = 32'h0060; orr = 32'h0003; size = 2'b10;
        if16.mem_rdata = 16'h00F0;
        do_reset();
        ack16_cycle();
        chk("t4_req_dec", if16.mem_req, 1'b0);
        tick();
        chk("t4_req_c", if16.mem_req, 1'b0);
        chk("t4_berr", be16, 1'b1);
        chk("t4_stall_c", st16, 1'b0);
        chk("t4_rvalid", rv16, 1'b0);
        tick();
        chk("t4_berr_end", be16, 1'b0);

        // access timeout then fetch timeout, late acks ignored
        pc = 32'h0070; orr = 32'h0004; size = 2'b01; wr = 32'h1234;
        if16.mem_rdata = 16'h00E0;
        do_reset();
        ack16_cycle();
        tick();
        chk("t5_a1_req", if16.mem_req, 1'b1);
        chk("t5_a1_be", if16.mem_be, 2'b01);
        chk("t5_a1_wdata", if16.mem_wdata, 16'h3434);
        tick(); tick(); tick();
        chk("t5_a4_req", if16.mem_req, 1'b1);
        tick();
        chk("t5_a5_req", if16.mem_req, 1'b0);
        chk("t5_a5_stall", st16, 1'b1);
        if16.mem_rdata = 16'h5678;
        ack16_cycle();
        chk("t5_c_berr", be16, 1'b1);
        chk("t5_c_rvalid", rv16, 1'b0);
        chk("t5_c_stall", st16, 1'b0);
        tick();
        chk("t5_f1_req", if16.mem_req, 1'b1);
        chk("t5_f1_berr", be16, 1'b0);
        tick(); tick(); tick();
        chk("t5_f4_req", if16.mem_req, 1'b1);
        tick();
        chk("t5_f5_req", if16.mem_req, 1'b0);
        if16.mem_rdata = 16'h0011;
        ack16_cycle();
        chk("t5_f6_berr", be16, 1'b1);
        chk("t5_f6_req", if16.mem_req, 1'b1);
        chk("t5_f6_instr", ins16, 8'hE0);
        chk("t5_f6_stall", st16, 1'b1);

        // reset while a push is waiting in ACCESS
        pc = 32'h0080; sp = 32'h0100; wr = 32'h5555; size = 2'b00;
        if16.mem_rdata = 16'h000A;
        do_reset();
        ack16_cycle();
        tick();
        chk("t6_req_acc", if16.mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_now", if16.mem_req, 1'b0);
        tick();
        chk("t6_req_rst", if16.mem_req, 1'b0);
        chk("t6_stall_rst", st16, 1'b1);
        chk("t6_instr_rst", ins16, 8'h00);
        pc = 32'h0123;
        rst_n = 1'b1;
        #1;
        chk("t6_fetch_addr", if16.mem_addr, 16'h0123);
        chk("t6_fetch_req", if16.mem_req, 1'b1);

        // 32-bit: byte pop with waits, halfword store and load
        pc = 32'h0020; sp = 32'h0105; size = 2'b01;
        if32.mem_rdata = 32'h0000_0009;
        do_reset();
        chk("t2_fetch_be", if32.mem_be, 4'b0001);
        ack32_cycle();
        chk("t2_instr_pop", ins32, 8'h09);
        tick();
        chk("t2_pop_addr", if32.mem_addr, 32'h0104);
        chk("t2_pop_be", if32.mem_be, 4'b0001);
        chk("t2_pop_we", if32.mem_we, 1'b0);
        tick(); tick(); tick();
        chk("t2_pop_req_w3", if32.mem_req, 1'b1);
        chk("t2_pop_addr_w3", if32.mem_addr, 32'h0104);
        if32.mem_rdata = 32'hA1B2_C3D4;
        ack32_cycle();
        chk("t2_pop_result", res32, 32'h0000_00D4);
        chk("t2_pop_reg", rr32, 4'h0);
        chk("t2_pop_rvalid", rv32, 1'b1);
        pc = 32'h0021; orr = 32'h0006; size = 2'b10;
        wr = 32'h1234_ABCD;
        if32.mem_rdata = 32'h0000_E000;
        tick();
        chk("t2_fetch_be1", if32.mem_be, 4'b0010);
        ack32_cycle();
        chk("t2_instr_str", ins32, 8'hE0);
        tick();
        chk("t2_str_be", if32.mem_be, 4'b1100);
        chk("t2_str_wdata", if32.mem_wdata, 32'hABCD_ABCD);
        chk("t2_str_we", if32.mem_we, 1'b1);
        chk("t2_str_addr", if32.mem_addr, 32'h0006);
        ack32_cycle();
        chk("t2_str_result", res32, 32'h1234_ABCD);
        chk("t2_str_rvalid", rv32, 1'b1);
        pc = 32'h0022;
        if32.mem_rdata = 32'h00F0_0000;
        tick();
        ack32_cycle();
        chk("t2_instr_load", ins32, 8'hF0);
        tick();
        chk("t2_load_we", if32.mem_we, 1'b0);
        chk("t2_load_be", if32.mem_be, 4'b1100);
        if32.mem_rdata = 32'h5566_7788;
        ack32_cycle();
        chk("t2_load_result", res32, 32'h0000_5566);
        chk("t2_load_rvalid", rv32, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
